// File: rtl/req_encoder_4_2_pkg.sv
// Shared types and helpers for the request priority encoder:
// FSM state encoding and a highest-set-bit encode function.
package req_encoder_4_2_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    localparam int MAX_N = 16;
    localparam int MAX_W = 4;

    // Later (higher) indices overwrite earlier ones, so the highest set bit wins.
    function automatic logic [MAX_W-1:0] prio_encode(input logic [MAX_N-1:0] vec);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (vec[i]) r = MAX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/req_encoder_4_2_prio_enc_comb.sv
// Pure combinational highest-set-bit encoder with an any-bit-set flag.
// Returns index 0 when no bit is set.
module prio_enc_comb
    import req_encoder_4_2_pkg::*;
#(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] enc,
    output logic         any
);

    always_comb begin
        enc = W'(prio_encode(MAX_N'(vec)));
        any = |vec;
    end

endmodule

// File: rtl/req_encoder_4_2.sv
// Sequential priority encoder: captures request strobes into a pending
// register and hands the highest pending index to one consumer via valid/ready.
module req_encoder_4_2
    import req_encoder_4_2_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         ready,
    input  logic         clr_ovf,
    output logic [W-1:0] idx,
    output logic         valid,
    output logic [N-1:0] pending,
    output logic         overflow
);

    state_t       state, state_next;
    logic [W-1:0] idx_next;
    logic         valid_next;
    logic [W-1:0] enc;
    logic         any;
    logic [N-1:0] retire_mask;
    logic [N-1:0] pending_next;
    logic         ovf_set;

    prio_enc_comb #(.N(N), .W(W)) u_enc (
        .vec (pending),
        .enc (enc),
        .any (any)
    );

    always_comb begin
        state_next  = state;
        idx_next    = idx;
        valid_next  = valid;
        retire_mask = '0;
        case (state)
            IDLE: begin
                if (any) begin
                    idx_next   = enc;
                    valid_next = 1'b1;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                // idx stays frozen here even if a higher line becomes pending.
                if (ready) begin
                    retire_mask = N'(1) << idx;
                    valid_next  = 1'b0;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A fresh request on a line being retired this edge re-arms it, not an overflow.
    assign pending_next = (pending & ~retire_mask) | req;
    assign ovf_set      = |(req & pending & ~retire_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            valid    <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            valid   <= valid_next;
            pending <= pending_next;
            if (ovf_set)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_req_encoder_4_2.sv
// Directed bench for req_encoder_4_2: a per-cycle vector table covering
// grant order, hold, re-request and overflow, plus an asynchronous reset sequence.
module tb_req_encoder_4_2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       ready;
    logic       clr_ovf;
    logic [1:0] idx;
    logic       valid;
    logic [3:0] pending;
    logic       overflow;

    int checks = 0;
    int passes = 0;

    req_encoder_4_2 #(.N(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .ready    (ready),
        .clr_ovf  (clr_ovf),
        .idx      (idx),
        .valid    (valid),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic       clr;
        logic       ev;
        logic [1:0] eidx;
        logic [3:0] epend;
        logic       eovf;
    } vec_t;

    localparam int NV = 36;
    vec_t tv [NV];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [1:0] ei,
                           input logic [3:0] ep, input logic eo);
        chk({tag, " valid"},    int'(valid),    int'(ev));
        chk({tag, " idx"},      int'(idx),      int'(ei));
        chk({tag, " pending"},  int'(pending),  int'(ep));
        chk({tag, " overflow"}, int'(overflow), int'(eo));
    endtask

    initial begin
        //            req     rdy clr  v  idx   pend    ovf
        // single pulse, then ready ignored while idle
        tv[0]  = '{4'b0100, 1, 0, 0, 2'd0, 4'b0100, 0};
        tv[1]  = '{4'b0000, 1, 0, 1, 2'd2, 4'b0100, 0};
        tv[2]  = '{4'b0000, 1, 0, 0, 2'd2, 4'b0000, 0};
        tv[3]  = '{4'b0000, 1, 0, 0, 2'd2, 4'b0000, 0};
        // multi-hot 1011 drains as 3,1,0
        tv[4]  = '{4'b1011, 1, 0, 0, 2'd2, 4'b1011, 0};
        tv[5]  = '{4'b0000, 1, 0, 1, 2'd3, 4'b1011, 0};
        tv[6]  = '{4'b0000, 1, 0, 0, 2'd3, 4'b0011, 0};
        tv[7]  = '{4'b0000, 1, 0, 1, 2'd1, 4'b0011, 0};
        tv[8]  = '{4'b0000, 1, 0, 0, 2'd1, 4'b0001, 0};
        tv[9]  = '{4'b0000, 1, 0, 1, 2'd0, 4'b0001, 0};
        tv[10] = '{4'b0000, 1, 0, 0, 2'd0, 4'b0000, 0};
        // hold with ready low; higher line arrives while presenting
        tv[11] = '{4'b0001, 0, 0, 0, 2'd0, 4'b0001, 0};
        tv[12] = '{4'b0000, 0, 0, 1, 2'd0, 4'b0001, 0};
        tv[13] = '{4'b0000, 0, 0, 1, 2'd0, 4'b0001, 0};
        tv[14] = '{4'b0000, 0, 0, 1, 2'd0, 4'b0001, 0};
        tv[15] = '{4'b0000, 0, 0, 1, 2'd0, 4'b0001, 0};
        tv[16] = '{4'b1000, 0, 0, 1, 2'd0, 4'b1001, 0};
        tv[17] = '{4'b0000, 0, 0, 1, 2'd0, 4'b1001, 0};
        tv[18] = '{4'b0000, 1, 0, 0, 2'd0, 4'b1000, 0};
        tv[19] = '{4'b0000, 1, 0, 1, 2'd3, 4'b1000, 0};
        tv[20] = '{4'b0000, 1, 0, 0, 2'd3, 4'b0000, 0};
        // same-edge re-request of the retired line
        tv[21] = '{4'b0100, 0, 0, 0, 2'd3, 4'b0100, 0};
        tv[22] = '{4'b0000, 0, 0, 1, 2'd2, 4'b0100, 0};
        tv[23] = '{4'b0100, 1, 0, 0, 2'd2, 4'b0100, 0};
        tv[24] = '{4'b0000, 0, 0, 1, 2'd2, 4'b0100, 0};
        tv[25] = '{4'b0000, 1, 0, 0, 2'd2, 4'b0000, 0};
        // overflow set, set-beats-clear, clear, collision on presented line
        tv[26] = '{4'b1010, 0, 0, 0, 2'd2, 4'b1010, 0};
        tv[27] = '{4'b0000, 0, 0, 1, 2'd3, 4'b1010, 0};
        tv[28] = '{4'b0010, 0, 0, 1, 2'd3, 4'b1010, 1};
        tv[29] = '{4'b0010, 0, 1, 1, 2'd3, 4'b1010, 1};
        tv[30] = '{4'b0000, 0, 1, 1, 2'd3, 4'b1010, 0};
        tv[31] = '{4'b1000, 0, 0, 1, 2'd3, 4'b1010, 1};
        tv[32] = '{4'b0000, 0, 1, 1, 2'd3, 4'b1010, 0};
        tv[33] = '{4'b0000, 1, 0, 0, 2'd3, 4'b0010, 0};
        tv[34] = '{4'b0000, 1, 0, 1, 2'd1, 4'b0010, 0};
        tv[35] = '{4'b0000, 1, 0, 0, 2'd1, 4'b0000, 0};

        rst = 1'b1; req = '0; ready = 1'b0; clr_ovf = 1'b0;
        #1;
        chk_all("reset@0", 0, 2'd0, 4'b0000, 0);
        req = 4'b1111; ready = 1'b1;
        @(posedge clk); #1;
        chk_all("reset held", 0, 2'd0, 4'b0000, 0);
        @(negedge clk);
        req = '0; ready = 1'b0; rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            req = tv[i].req; ready = tv[i].rdy; clr_ovf = tv[i].clr;
            @(posedge clk); #1;
            chk_all($sformatf("vec%0d", i), tv[i].ev, tv[i].eidx, tv[i].epend, tv[i].eovf);
        end

        // Asynchronous reset while presenting with overflow set.
        @(negedge clk);
        req = 4'b1010; ready = 1'b0; clr_ovf = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req = 4'b0010;
        @(posedge clk); #1;
        chk_all("pre-reset", 1, 2'd3, 4'b1010, 1);
        @(negedge clk);
        req = '0;
        #2 rst = 1'b1;
        #1;
        chk_all("async reset", 0, 2'd0, 4'b0000, 0);
        #1 rst = 1'b0;
        ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk($sformatf("post-reset valid c%0d", c), int'(valid), 0);
            chk($sformatf("post-reset pending c%0d", c), int'(pending), 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/req_encoder_4_2.md
Name: req_encoder_4_2

Overview:
- Sequential 4-to-2 priority encoder; the inverse of the team's 2x4 one-hot decoder.
- Captures request pulses on N lines into a pending register.
- Presents the binary index of the highest-numbered pending line to a consumer over a valid/ready handshake, then retires the served bit.
- Sits between event sources (decoder outputs, interrupt-style strobes) and a single downstream consumer.

Parameters:
- N, 4, number of request lines (2..16).
- W, $clog2(N) (2 at default), width of the encoded index; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request strobes, sampled each rising edge; multi-hot allowed.
- ready  input  1  consumer accepts the current index when high with valid.
- clr_ovf  input  1  synchronous clear of the overflow flag.
- idx  output  W  encoded index of the presented request.
- valid  output  1  idx is meaningful.
- pending  output  N  current pending register (debug/status).
- overflow  output  1  sticky; a request arrived on a line that was already pending.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (rst=1, immediate, no clock needed):
  - pending=0, idx=0, valid=0, overflow=0, state=IDLE.
  - Reset mid-handshake discards everything; no grant is issued after release until new req.
- Capture: each edge, pending_next = (pending & ~retire_mask) | req. A req bit arriving on the same edge its line is retired keeps the bit set; the new request wins.
- Priority: highest set index wins (pending[N-1] highest). Encoding is combinational from pending, registered into idx.
- State machine, registered outputs:
  - IDLE: valid=0. If pending!=0 at an edge, load idx=encode(pending), valid=1, go PRESENT. req is not bypassed; it must be in pending first.
  - PRESENT: valid=1; idx is frozen, even if a higher-priority line becomes pending.
    - ready=1 at an edge: retire_mask=onehot(idx), valid=0, go IDLE.
    - ready=0: hold.
- Latency:
  - req high at edge t -> pending bit visible after t -> valid/idx after edge t+1 (from IDLE).
  - Handshake at edge t -> valid low for cycle t..t+1 -> next grant valid after edge t+1 if pending is still nonzero.
  - Maximum throughput: one grant per 2 cycles.
- Overflow: set at any edge where req[i]=1 and pending[i]=1 and line i is not retired that edge.
  - Cleared by clr_ovf=1 at an edge.
  - Set has priority over clear in the same cycle.
- ready while valid=0 is ignored. idx holds its last value when valid=0.
- N not a power of two: idx values >= N are never produced.

Decomposition:
- Shared package: state enum (IDLE, PRESENT) and a function prio_encode(N-bit) -> W-bit that returns the highest set index, or 0 for all-zero input.
- One natural sub-module: prio_enc_comb (pure combinational highest-set-bit encoder, with an any output). It is reusable against the team's decoder for loopback tests.
- Top-level holds the pending register, FSM, overflow logic.

Test Plan:
- Reset during PRESENT (pending=4'b1010, valid=1, rst pulsed mid-cycle) -> valid, pending, overflow drop to 0 immediately without a clock edge; nothing granted after release.
- Single pulse req=4'b0100 at edge t, ready=1 -> valid=1, idx=2 after t+1; after handshake pending=0, valid=0 and stays 0.
- Multi-hot req=4'b1011 in one cycle, ready=1 throughout -> grants idx=3,1,0 in order, each valid for 1 cycle with a 1-cycle gap; pending ends 0.
- Hold/stability: req=4'b0001, ready=0 for 5 cycles, then req=4'b1000 while PRESENT -> idx stays 0 until ready; then grants 3.
- Same-edge re-request: in PRESENT with idx=2, ready=1 and req=4'b0100 on the same edge -> pending[2] stays 1, overflow stays 0, idx=2 granted again 2 cycles later.
- Overflow: pending[1]=1 (not presented, since a higher line is pending) and req=4'b0010 -> overflow=1. With clr_ovf=1 and a fresh collision on the same edge, overflow stays 1. Next clr_ovf alone -> 0.
